// File: rtl/adc_spi_sampler.sv
// Periodic SPI-ADC reader (mode 0, read-only). Each trigger runs one chip-select frame and
// publishes the captured sample with a one-cycle strobe; triggers that arrive mid-frame set a sticky overrun flag.
module adc_spi_sampler #(
   parameter int DATA_BITS     = 10,
   parameter int LEAD_BITS     = 2,
   parameter int CLK_DIV       = 2,
   parameter int SAMPLE_PERIOD = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 adc_miso,
   output logic                 adc_sclk,
   output logic                 adc_cs_n,
   output logic [DATA_BITS-1:0] sample_out,
   output logic                 strobe_out,
   output logic                 overrun_out
);

   localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
   localparam int CNT_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_PUB   = 3'd4;

   logic [2:0]           state;
   logic [CNT_W-1:0]     trig_cnt;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] hold_reg;
   logic                 trig;
   logic                 div_done;

   assign trig     = ena && (trig_cnt == CNT_LAST);
   assign div_done = (div_cnt == DIV_LAST);

   // Free-running trigger timebase; frozen while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_cnt <= '0;
      end else if (ena) begin
         trig_cnt <= (trig_cnt == CNT_LAST) ? '0 : trig_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_out <= 1'b0;
      end else if (trig && (state != S_IDLE)) begin
         overrun_out <= 1'b1;
      end
   end

   // Frame sequencer; cs_n and sclk are registered so they change only with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         hold_reg   <= '0;
         adc_cs_n   <= 1'b1;
         adc_sclk   <= 1'b0;
         sample_out <= '0;
         strobe_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               strobe_out <= 1'b0;
               adc_cs_n   <= 1'b1;
               adc_sclk   <= 1'b0;
               if (trig) begin
                  state    <= S_SETUP;
                  adc_cs_n <= 1'b0;
                  div_cnt  <= '0;
               end
            end
            S_SETUP: begin
               if (div_done) begin
                  state   <= S_SHIFT;
                  div_cnt <= '0;
                  bit_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_SHIFT: begin
               if (!div_done) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else if (!adc_sclk) begin
                  // Rising sclk edge: capture MSB-first; lead bits fall off the top.
                  div_cnt  <= '0;
                  adc_sclk <= 1'b1;
                  hold_reg <= {hold_reg[DATA_BITS-2:0], adc_miso};
               end else begin
                  div_cnt  <= '0;
                  adc_sclk <= 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     state <= S_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (div_done) begin
                  state      <= S_PUB;
                  div_cnt    <= '0;
                  adc_cs_n   <= 1'b1;
                  sample_out <= hold_reg;
                  strobe_out <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_PUB: begin
               state      <= S_IDLE;
               strobe_out <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               adc_cs_n   <= 1'b1;
               adc_sclk   <= 1'b0;
               strobe_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench: three sampler configurations checked against hand-computed edge tables,
// then mid-frame reset and ena-freeze sequences on the default instance.
module tb_adc_spi_sampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_bc, ena;
   logic miso_a, miso_b, miso_c;
   logic cs_a, cs_b, cs_c, sclk_a, sclk_b, sclk_c;
   logic stb_a, stb_b, stb_c, ovr_a, ovr_b, ovr_c;
   logic [9:0] smp_a, smp_b, smp_c;

   adc_spi_sampler u_a (
      .clk(clk), .rst_n(rst_a), .ena(ena), .adc_miso(miso_a), .adc_sclk(sclk_a),
      .adc_cs_n(cs_a), .sample_out(smp_a), .strobe_out(stb_a), .overrun_out(ovr_a));

   adc_spi_sampler #(.SAMPLE_PERIOD(40)) u_b (
      .clk(clk), .rst_n(rst_bc), .ena(ena), .adc_miso(miso_b), .adc_sclk(sclk_b),
      .adc_cs_n(cs_b), .sample_out(smp_b), .strobe_out(stb_b), .overrun_out(ovr_b));

   adc_spi_sampler #(.CLK_DIV(1), .LEAD_BITS(0), .SAMPLE_PERIOD(30)) u_c (
      .clk(clk), .rst_n(rst_bc), .ena(ena), .adc_miso(miso_c), .adc_sclk(sclk_c),
      .adc_cs_n(cs_c), .sample_out(smp_c), .strobe_out(stb_c), .overrun_out(ovr_c));

   // ADC models: first bit on cs_n fall, next bit on each sclk fall; one table entry per frame.
   logic [11:0] fr_a [0:7];
   logic [11:0] fr_b [0:3];
   logic [9:0]  fr_c [0:3];
   int fi_a = 0, bi_a = 0, fi_b = 0, bi_b = 0, fi_c = 0, bi_c = 0;

   always @(negedge cs_a) begin bi_a = 11; miso_a = fr_a[fi_a][bi_a]; fi_a++; end
   always @(negedge sclk_a) if (!cs_a && bi_a > 0) begin bi_a--; miso_a = fr_a[fi_a-1][bi_a]; end
   always @(negedge cs_b) begin bi_b = 11; miso_b = fr_b[fi_b][bi_b]; fi_b++; end
   always @(negedge sclk_b) if (!cs_b && bi_b > 0) begin bi_b--; miso_b = fr_b[fi_b-1][bi_b]; end
   always @(negedge cs_c) begin bi_c = 9; miso_c = fr_c[fi_c][bi_c]; fi_c++; end
   always @(negedge sclk_c) if (!cs_c && bi_c > 0) begin bi_c--; miso_c = fr_c[fi_c-1][bi_c]; end

   int cs_low_a = 0, rises_a = 0, cs_fall_a = 0;
   always @(negedge clk) if (cs_a === 1'b0) cs_low_a++;
   always @(posedge sclk_a) rises_a++;
   always @(negedge cs_a) cs_fall_a++;

   int errors = 0, checks = 0, ecnt = -1;

   typedef struct {
      int         ecyc;
      int         dut;
      logic       cs;
      logic       sc;
      logic       stb;
      logic [9:0] smp;
      logic       ovr;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance to the negedge following posedge number e (edge 0 = first after release).
   task automatic adv_to(input int e);
      if (ecnt < e) begin
         while (ecnt < e) begin @(posedge clk); ecnt++; end
         @(negedge clk);
      end
   endtask

   task automatic addv(input int e, input int d, input logic cs, input logic sc,
                       input logic stb, input logic [9:0] smp, input logic ovr);
      vec_t v;
      v.ecyc = e; v.dut = d; v.cs = cs; v.sc = sc; v.stb = stb; v.smp = smp; v.ovr = ovr;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cf0;
      logic acs, asc, astb, aovr;
      logic [9:0] asmp;
      fr_a[0] = {2'b00, 10'h2A5}; fr_a[1] = {2'b11, 10'h000}; fr_a[2] = {2'b11, 10'h3FF};
      fr_a[3] = {2'b00, 10'h155}; fr_a[4] = {2'b01, 10'h1B6}; fr_a[5] = {2'b10, 10'h0CA};
      fr_a[6] = {2'b00, 10'h31D}; fr_a[7] = '0;
      fr_b[0] = {2'b00, 10'h0F5}; fr_b[1] = {2'b10, 10'h2C3}; fr_b[2] = '0; fr_b[3] = '0;
      fr_c[0] = 10'h1C3; fr_c[1] = 10'h24A; fr_c[2] = 10'h3E1; fr_c[3] = '0;

      //     edge dut cs sclk stb sample  ovr
      addv(  0, 0, 1, 0, 0, 10'h000, 0);
      addv(  0, 1, 1, 0, 0, 10'h000, 0);
      addv( 28, 2, 1, 0, 0, 10'h000, 0);
      addv( 29, 2, 0, 0, 0, 10'h000, 0);
      addv( 30, 2, 0, 0, 0, 10'h000, 0);
      addv( 31, 2, 0, 1, 0, 10'h000, 0);
      addv( 32, 2, 0, 0, 0, 10'h000, 0);
      addv( 38, 1, 1, 0, 0, 10'h000, 0);
      addv( 39, 1, 0, 0, 0, 10'h000, 0);
      addv( 50, 2, 0, 0, 0, 10'h000, 0);
      addv( 51, 2, 1, 0, 1, 10'h1C3, 0);
      addv( 52, 2, 1, 0, 0, 10'h1C3, 0);
      addv( 62, 0, 1, 0, 0, 10'h000, 0);
      addv( 63, 0, 0, 0, 0, 10'h000, 0);
      addv( 66, 0, 0, 0, 0, 10'h000, 0);
      addv( 67, 0, 0, 1, 0, 10'h000, 0);
      addv( 78, 1, 0, 0, 0, 10'h000, 0);
      addv( 79, 1, 0, 1, 0, 10'h000, 1);
      addv( 81, 2, 1, 0, 1, 10'h24A, 0);
      addv( 91, 1, 1, 0, 1, 10'h0F5, 1);
      addv( 92, 1, 1, 0, 0, 10'h0F5, 1);
      addv(111, 2, 1, 0, 1, 10'h3E1, 0);
      addv(113, 0, 0, 0, 0, 10'h000, 0);
      addv(114, 0, 0, 0, 0, 10'h000, 0);
      addv(115, 0, 1, 0, 1, 10'h2A5, 0);
      addv(116, 0, 1, 0, 0, 10'h2A5, 0);
      addv(118, 1, 1, 0, 0, 10'h0F5, 1);
      addv(119, 1, 0, 0, 0, 10'h0F5, 1);
      addv(171, 1, 1, 0, 1, 10'h2C3, 1);
      addv(178, 0, 0, 0, 0, 10'h2A5, 0);
      addv(179, 0, 1, 0, 1, 10'h000, 0);
      addv(243, 0, 1, 0, 1, 10'h3FF, 0);

      ena = 1'b1; rst_a = 1'b0; rst_bc = 1'b0;
      miso_a = 1'b0; miso_b = 1'b0; miso_c = 1'b0;
      repeat (3) @(negedge clk);
      rst_a = 1'b1; rst_bc = 1'b1;
      cs_low_a = 0; rises_a = 0; cs_fall_a = 0; ecnt = -1;

      foreach (vecs[i]) begin
         adv_to(vecs[i].ecyc);
         case (vecs[i].dut)
            0:       begin acs = cs_a; asc = sclk_a; astb = stb_a; asmp = smp_a; aovr = ovr_a; end
            1:       begin acs = cs_b; asc = sclk_b; astb = stb_b; asmp = smp_b; aovr = ovr_b; end
            default: begin acs = cs_c; asc = sclk_c; astb = stb_c; asmp = smp_c; aovr = ovr_c; end
         endcase
         chk($sformatf("v%0d d%0d e%0d cs_n", i, vecs[i].dut, vecs[i].ecyc), 32'(acs), 32'(vecs[i].cs));
         chk($sformatf("v%0d d%0d e%0d sclk", i, vecs[i].dut, vecs[i].ecyc), 32'(asc), 32'(vecs[i].sc));
         chk($sformatf("v%0d d%0d e%0d strobe", i, vecs[i].dut, vecs[i].ecyc), 32'(astb), 32'(vecs[i].stb));
         chk($sformatf("v%0d d%0d e%0d sample", i, vecs[i].dut, vecs[i].ecyc), 32'(asmp), 32'(vecs[i].smp));
         chk($sformatf("v%0d d%0d e%0d overrun", i, vecs[i].dut, vecs[i].ecyc), 32'(aovr), 32'(vecs[i].ovr));
      end

      // Three full default frames: 52 cs_n-low cycles and 12 sclk rises each.
      chk("cs_low_cycles_3frames", 32'(cs_low_a), 32'd156);
      chk("sclk_rises_3frames", 32'(rises_a), 32'd36);

      // Reset asserted mid-frame, right after the 5th sclk rise of the frame starting at edge 255.
      adv_to(275);
      chk("pre_reset_sclk_high", 32'(sclk_a), 32'd1);
      chk("pre_reset_cs_low", 32'(cs_a), 32'd0);
      rst_a = 1'b0;
      #1;
      chk("reset_cs_n_async", 32'(cs_a), 32'd1);
      chk("reset_sclk_async", 32'(sclk_a), 32'd0);
      chk("reset_sample", 32'(smp_a), 32'd0);
      chk("reset_strobe", 32'(stb_a), 32'd0);
      chk("reset_overrun", 32'(ovr_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      ecnt = -1;

      adv_to(114);
      chk("post_reset_no_early_publish", 32'(smp_a), 32'd0);
      chk("post_reset_no_early_strobe", 32'(stb_a), 32'd0);
      adv_to(115);
      chk("post_reset_strobe", 32'(stb_a), 32'd1);
      chk("post_reset_sample", 32'(smp_a), 32'h1B6);

      // ena low for edges 141..240 while the frame triggered at edge 127 is in flight.
      adv_to(140);
      cf0 = cs_fall_a;
      ena = 1'b0;
      adv_to(179);
      chk("ena_low_frame_strobe", 32'(stb_a), 32'd1);
      chk("ena_low_frame_sample", 32'(smp_a), 32'h0CA);
      adv_to(240);
      chk("ena_low_no_cs_fall", 32'(cs_fall_a - cf0), 32'd0);
      chk("ena_low_idle_cs", 32'(cs_a), 32'd1);
      ena = 1'b1;
      // Counter froze at 13, so 50 more enabled edges reach the next trigger.
      adv_to(290);
      chk("resume_cs_still_high", 32'(cs_a), 32'd1);
      adv_to(291);
      chk("resume_cs_fall", 32'(cs_a), 32'd0);
      adv_to(343);
      chk("resume_strobe", 32'(stb_a), 32'd1);
      chk("resume_sample", 32'(smp_a), 32'h31D);
      chk("resume_overrun", 32'(ovr_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
